full_logic_merge: RTL

- Transmit-side counterpart of the full_logic demux: merges two 6-bit lanes, D0 and D1, into the single 6-bit stream that feeds the main FIFO path.
- Each lane has its own ingress FIFO.
- A round-robin arbiter drains the two FIFOs under downstream back-pressure (pause_in).
- The control FSM (INIT/IDLE/ACTIVE/ERROR) and its status outputs are the same as full_logic's, so benches can probe either end identically.

---
 rtl/full_logic_merge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/full_logic_merge.sv
// Two-lane transmit merge: each lane has its own ingress FIFO, and a round-robin
// arbiter drains them into one registered stream. The INIT/IDLE/ACTIVE/ERROR FSM matches full_logic.
module full_logic_merge #(
  parameter int DATA_WIDTH = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_Ds,
  input  logic                  push_D0,
  input  logic                  push_D1,
  input  logic [DATA_WIDTH-1:0] data_in_D0,
  input  logic [DATA_WIDTH-1:0] data_in_D1,
  input  logic                  pause_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  almost_full_D0,
  output logic                  almost_full_D1,
  output logic                  error_D0,
  output logic                  error_D1,
  output logic                  error_out,
  output logic                  active_out,
  output logic                  idle_out
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [3:0]          UMBRAL_RST = 4'(FIFO_DEPTH - 1);

  state_t                state_q, state_d;
  logic [3:0]            umbral_q, umbral_d;
  logic                  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;

  logic [1:0]                       push, wr_en, ovf, not_empty, pop, err_q, almost_full;
  logic [1:0][DATA_WIDTH-1:0]       lane_din, lane_rd;

  assign push        = {push_D1, push_D0};
  assign lane_din[0] = data_in_D0;
  assign lane_din[1] = data_in_D1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [ADDR_WIDTH:0]   count_q, count_d;
      logic                  err_lane_q, err_lane_d;
      logic                  full;

      // Full is judged on the pre-edge count, so a same-cycle pop cannot rescue a push.
      assign full              = (count_q == DEPTH_C);
      assign wr_en[gi]         = push[gi] && !full;
      assign ovf[gi]           = push[gi] && full;
      assign not_empty[gi]     = (count_q != '0);
      assign almost_full[gi]   = (count_q >= umbral_q);
      assign lane_rd[gi]       = mem[rd_ptr_q];
      assign err_q[gi]         = err_lane_q;

      always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_lane_d = err_lane_q | ovf[gi];
        if (wr_en[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop[gi])   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en[gi], pop[gi]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_q   <= '0;
          rd_ptr_q   <= '0;
          count_q    <= '0;
          err_lane_q <= 1'b0;
        end else begin
          wr_ptr_q   <= wr_ptr_d;
          rd_ptr_q   <= rd_ptr_d;
          count_q    <= count_d;
          err_lane_q <= err_lane_d;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem[wr_ptr_q] <= lane_din[gi];
      end
    end
  endgenerate

  // rr_q = 0 means lane D0 wins the next tie.
  always_comb begin
    pop        = 2'b00;
    rr_d       = rr_q;
    valid_d    = 1'b0;
    data_out_d = data_out_q;
    if (state_q == ST_ACTIVE && !pause_in) begin
      if (not_empty[0] && not_empty[1]) begin
        pop[rr_q] = 1'b1;
        rr_d      = ~rr_q;
      end else if (not_empty[0]) begin
        pop[0] = 1'b1;
        rr_d   = 1'b1;
      end else if (not_empty[1]) begin
        pop[1] = 1'b1;
        rr_d   = 1'b0;
      end
    end
    if (|pop) begin
      valid_d    = 1'b1;
      data_out_d = pop[1] ? lane_rd[1] : lane_rd[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    umbral_d = umbral_q;
    case (state_q)
      ST_INIT: begin
        umbral_d = umbral_Ds;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)            state_d = ST_INIT;
        else if (|not_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                        state_d = ST_INIT;
        else if (!(|not_empty) && !(|pop)) state_d = ST_IDLE;
      end
      default: state_d = ST_ERROR;
    endcase
    // Overflow outranks every other transition except while initialising.
    if (|ovf && state_q != ST_INIT) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      umbral_q   <= UMBRAL_RST;
      rr_q       <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      umbral_q   <= umbral_d;
      rr_q       <= rr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out       = data_out_q;
  assign valid_out      = valid_q;
  assign almost_full_D0 = almost_full[0];
  assign almost_full_D1 = almost_full[1];
  assign error_D0       = err_q[0];
  assign error_D1       = err_q[1];
  assign error_out      = (state_q == ST_ERROR);
  assign active_out     = (state_q == ST_ACTIVE);
  assign idle_out       = (state_q == ST_IDLE);

endmodule
